// File: rtl/apu_sweep_bank.sv
// Multi-channel RP2A03 note-sweep engine: one shared shift/add datapath,
// time-multiplexed over CHANNELS sweep units by a free-running pointer.
module apu_sweep_bank #(
  parameter int                  CHANNELS            = 2,
  parameter int                  TIMER_WIDTH         = 11,
  parameter logic [CHANNELS-1:0] TWOS_COMPLEMENT_MASK = 2'b10
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [CHANNELS-1:0]             sweep_setup_reg_wr_i,
  input  logic [7:0]                      channel_regs_wr_data_i,
  input  logic                            half_frame_i,
  input  logic [CHANNELS*TIMER_WIDTH-1:0] timer_value_i,
  output logic [CHANNELS-1:0]             muting_is_inactive_o,
  output logic [CHANNELS*TIMER_WIDTH-1:0] target_timer_value_o,
  output logic [CHANNELS-1:0]             timer_value_update_o
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [TIMER_WIDTH:0]   ONE       = 1;
  localparam logic [TIMER_WIDTH-1:0] MIN_TIMER = 8;
  localparam logic [PTR_W-1:0]       LAST_PTR  = PTR_W'(CHANNELS - 1);

  typedef struct packed {
    logic       enable;
    logic [2:0] period;
    logic       negate;
    logic [2:0] shift;
  } setup_t;

  setup_t        setup   [CHANNELS];
  logic [2:0]    counter [CHANNELS];
  logic [CHANNELS-1:0] reload;
  logic [CHANNELS-1:0] pending;
  logic [PTR_W-1:0]    ptr;

  setup_t                 cur;
  logic [TIMER_WIDTH-1:0] t_cur;
  logic [TIMER_WIDTH:0]   chg;
  logic [TIMER_WIDTH:0]   sum;
  logic                   ovf;
  logic                   unmuted;
  logic [TIMER_WIDTH-1:0] target;
  logic                   eff_pending;
  logic                   fire;

  // Shared datapath: evaluates the channel selected by ptr this cycle.
  always_comb begin
    cur   = setup[ptr];
    t_cur = timer_value_i[ptr*TIMER_WIDTH +: TIMER_WIDTH];
    chg   = {1'b0, t_cur} >> cur.shift;
    if (cur.negate) begin
      chg = TWOS_COMPLEMENT_MASK[ptr] ? (~chg + ONE) : ~chg;
    end
    sum         = {1'b0, t_cur} + chg;
    ovf         = sum[TIMER_WIDTH];
    target      = ovf ? '0 : sum[TIMER_WIDTH-1:0];
    unmuted     = (t_cur >= MIN_TIMER) && !ovf;
    eff_pending = pending[ptr] | half_frame_i;
    fire        = eff_pending && (counter[ptr] == 3'd0) && cur.enable &&
                  (cur.shift != 3'd0) && unmuted;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr                  <= '0;
      reload               <= '0;
      pending              <= '0;
      muting_is_inactive_o <= '0;
      target_timer_value_o <= '0;
      timer_value_update_o <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        setup[k]   <= '0;
        counter[k] <= '0;
      end
    end else begin
      ptr <= (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);

      target_timer_value_o[ptr*TIMER_WIDTH +: TIMER_WIDTH] <= target;
      muting_is_inactive_o[ptr]                            <= unmuted;

      timer_value_update_o <= '0;
      if (fire) timer_value_update_o[ptr] <= 1'b1;

      // A half-frame landing on the serviced slot is consumed by this service.
      if (half_frame_i) pending <= '1;
      pending[ptr] <= 1'b0;

      if (eff_pending) begin
        if ((counter[ptr] == 3'd0) || reload[ptr]) begin
          counter[ptr] <= cur.period;
          reload[ptr]  <= 1'b0;
        end else begin
          counter[ptr] <= counter[ptr] - 3'd1;
        end
      end

      // NOTE: the later non-blocking assignment wins, so a register write
      // sets reload even when the same cycle's service clears it.
      for (int k = 0; k < CHANNELS; k++) begin
        if (sweep_setup_reg_wr_i[k]) begin
          setup[k]  <= channel_regs_wr_data_i;
          reload[k] <= 1'b1;
        end
      end
    end
  end

endmodule
